// File: rtl/sprite_line_renderer.sv
// sprite_line_renderer: double-buffered 1-bit scanline compositor fed from a sprite-sheet ROM
package sprite_line_renderer_pkg;
  typedef struct packed {
    logic [11:0] x;
    logic [11:0] y;
    logic [11:0] w;
    logic [11:0] h;
  } sprite_t;
endpackage

module sprite_line_renderer
  import sprite_line_renderer_pkg::*;
#(
  parameter int SCREEN_W     = 1200,
  parameter int SHEET_W      = 2446,
  parameter int ROM_AW       = 19,
  parameter int RENDER_SLOTS = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  sprite_t           sprite [RENDER_SLOTS],
  input  logic [10:0]       pos [RENDER_SLOTS][2],
  input  logic              line_req,
  input  logic [9:0]        line_y,
  output logic              busy,
  output logic              line_done,
  output logic              overrun,
  output logic [ROM_AW-1:0] rom_addr,
  output logic              rom_rd,
  input  logic              rom_data,
  input  logic [10:0]       rd_x,
  output logic              rd_pixel
);
  localparam int SW = RENDER_SLOTS > 1 ? $clog2(RENDER_SLOTS) : 1;
  typedef enum logic [2:0] {IDLE, CLEAR, SCAN, FETCH, DRAIN, DONE} state_t;
  state_t state;
  logic [SW-1:0] slot;
  logic [9:0] ly;
  logic [11:0] col, w_q;
  logic [31:0] base_q, base_c;
  logic signed [11:0] px_q, px_c, iss_sx, pend_sx;
  logic pend_v, bank;
  logic [SCREEN_W-1:0] buf0, buf1;
  sprite_t cur;
  logic [10:0] cur_x, cur_y, row, wa;
  logic hit, last, we, wd;
  // slot decode for the slot under SCAN and the back-buffer write port
  always_comb begin
    cur = sprite[slot];
    cur_x = pos[slot][0];
    cur_y = pos[slot][1];
    row = {1'b0, ly} - cur_y;
    hit = cur.w != 12'd0 && cur.h != 12'd0 && {1'b0, ly} >= cur_y && {1'b0, row} < cur.h;
    last = slot == SW'(RENDER_SLOTS - 1);
    base_c = (32'(cur.y) + 32'(row)) * 32'(SHEET_W) + 32'(cur.x);
    px_c = {cur_x[10], cur_x};
    we = state == CLEAR || (pend_v && rom_data && !pend_sx[11] && pend_sx[10:0] < 11'(SCREEN_W));
    wa = state == CLEAR ? col[10:0] : pend_sx[10:0];
    wd = state != CLEAR;
  end
  // render sequencer: clear back buffer, scan slots, fetch hit rows from ROM
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy <= 1'b0;
      line_done <= 1'b0;
      overrun <= 1'b0;
      rom_rd <= 1'b0;
      rom_addr <= '0;
      bank <= 1'b0;
      slot <= '0;
      col <= '0;
      ly <= '0;
      w_q <= '0;
      base_q <= '0;
      px_q <= '0;
      iss_sx <= '0;
      pend_v <= 1'b0;
      pend_sx <= '0;
    end else begin
      line_done <= 1'b0;
      pend_v <= rom_rd;
      pend_sx <= iss_sx;
      if (line_req && state != IDLE) overrun <= 1'b1;
      case (state)
        IDLE: if (line_req) begin
          bank <= ~bank;
          ly <= line_y;
          slot <= '0;
          col <= '0;
          busy <= 1'b1;
          state <= CLEAR;
        end
        CLEAR: begin
          col <= col == 12'(SCREEN_W - 1) ? '0 : col + 1'b1;
          if (col == 12'(SCREEN_W - 1)) state <= SCAN;
        end
        SCAN: if (hit) begin
          w_q <= cur.w;
          base_q <= base_c;
          px_q <= px_c;
          rom_rd <= 1'b1;
          rom_addr <= ROM_AW'(base_c);
          iss_sx <= px_c;
          col <= 12'd1;
          state <= FETCH;
        end else begin
          slot <= slot + 1'b1;
          if (last) state <= DONE;
        end
        FETCH: if (col == w_q) begin
          rom_rd <= 1'b0;
          state <= DRAIN;
        end else begin
          rom_addr <= ROM_AW'(base_q + 32'(col));
          iss_sx <= px_q + $signed(col);
          col <= col + 1'b1;
        end
        DRAIN: begin
          slot <= slot + 1'b1;
          state <= last ? DONE : SCAN;
        end
        DONE: begin
          busy <= 1'b0;
          line_done <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  // line buffers: render writes the back bank, display reads the front bank
  always_ff @(posedge clk) begin
    if (rst) begin
      buf0 <= '0;
      buf1 <= '0;
      rd_pixel <= 1'b0;
    end else begin
      if (we && bank) buf0[wa] <= wd;
      if (we && !bank) buf1[wa] <= wd;
      rd_pixel <= rd_x < 11'(SCREEN_W) && (bank ? buf1[rd_x] : buf0[rd_x]);
    end
  end
endmodule

// File: tb/tb_sprite_line_renderer.sv
// tb_sprite_line_renderer: directed scoreboard bench for sprite_line_renderer
module tb_sprite_line_renderer;
  import sprite_line_renderer_pkg::*;
  localparam int SCREEN_W = 1200;
  localparam int NS = 32;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic line_req = 1'b0;
  logic [9:0] line_y = '0;
  logic [10:0] rd_x = '0;
  logic rom_data;
  logic busy, line_done, overrun, rom_rd, rd_pixel;
  logic [18:0] rom_addr;
  sprite_t sprite [NS];
  logic [10:0] pos [NS][2];
  int n_chk = 0;
  int n_fail = 0;
  int rom_mode = 0;
  logic rd_tag = 1'b0;
  logic rd_tag_d = 1'b0;
  int exp_q[$];
  bit exp_img [SCREEN_W];

  always #5 clk = ~clk;

  sprite_line_renderer dut (
    .clk(clk), .rst(rst), .sprite(sprite), .pos(pos), .line_req(line_req), .line_y(line_y),
    .busy(busy), .line_done(line_done), .overrun(overrun), .rom_addr(rom_addr), .rom_rd(rom_rd),
    .rom_data(rom_data), .rd_x(rd_x), .rd_pixel(rd_pixel)
  );

  function automatic logic rom_fn(input logic [18:0] a);
    case (rom_mode)
      1: return 1'b1;
      2: return a < 19'd100000;
      3: return a[0];
      default: return 1'b0;
    endcase
  endfunction

  function automatic void check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  always @(posedge clk) rom_data <= rom_rd && rom_fn(rom_addr);
  always @(posedge clk) rd_tag_d <= rd_tag;

  always @(negedge clk) begin
    if (rd_tag_d) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL rd_pixel: output with no expected entry, got %0d", rd_pixel);
      end else begin
        int v;
        v = exp_q.pop_front();
        check($sformatf("rd_pixel x=%0d", v >>> 1), int'(rd_pixel), v & 1);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_slots();
    for (int i = 0; i < NS; i++) begin
      sprite[i] = '0;
      pos[i][0] = '0;
      pos[i][1] = '0;
    end
  endtask

  task automatic set_slot(input int s, input int sx, input int sy, input int w, input int h,
                          input int px, input int py);
    sprite[s] = '{x: 12'(sx), y: 12'(sy), w: 12'(w), h: 12'(h)};
    pos[s][0] = 11'(px);
    pos[s][1] = 11'(py);
  endtask

  task automatic zero_img();
    for (int i = 0; i < SCREEN_W; i++) exp_img[i] = 1'b0;
  endtask

  task automatic set_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) exp_img[i] = 1'b1;
  endtask

  task automatic start(input int ly);
    line_y = 10'(ly);
    line_req = 1'b1;
    tick();
    line_req = 1'b0;
  endtask

  task automatic wait_done(output int cyc, output int first);
    cyc = 0;
    first = -1;
    while (cyc < 20000) begin
      tick();
      cyc++;
      if (rom_rd && first < 0) first = int'(rom_addr);
      if (line_done) break;
    end
    if (!line_done) begin
      n_chk++;
      n_fail++;
      $display("FAIL render_timeout: no line_done after %0d cycles", cyc);
    end
  endtask

  task automatic render(input int ly, output int cyc, output int first);
    start(ly);
    wait_done(cyc, first);
  endtask

  task automatic read_front();
    for (int x = 0; x < SCREEN_W + 4; x++) begin
      rd_x = 11'(x);
      rd_tag = 1'b1;
      exp_q.push_back(x * 2 + ((x < SCREEN_W && exp_img[x]) ? 1 : 0));
      tick();
    end
    rd_tag = 1'b0;
    tick();
    tick();
    check("queue_drained", exp_q.size(), 0);
  endtask

  task automatic show();
    int c, f;
    clear_slots();
    render(0, c, f);
    read_front();
  endtask

  initial begin
    int c, f, c2;
    clear_slots();
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rst_busy", busy, 0);
    check("rst_line_done", line_done, 0);
    check("rst_overrun", overrun, 0);
    check("rst_rom_rd", rom_rd, 0);
    check("rst_rom_addr", int'(rom_addr), 0);
    check("rst_rd_pixel", rd_pixel, 0);
    zero_img();
    read_front();

    render(10, c, f);
    check("empty_latency", c, 1233);
    check("empty_no_rom_read", f, -1);
    check("empty_busy_after", busy, 0);
    show();

    clear_slots();
    rom_mode = 1;
    set_slot(29, 1678, 2, 88, 94, 100, 50);
    render(60, c, f);
    check("single_latency", c, 1322);
    check("single_first_addr", f, 31030);
    zero_img();
    set_range(100, 187);
    show();

    clear_slots();
    set_slot(5, 0, 0, 20, 1, -10, 7);
    render(7, c, f);
    check("clip_latency", c, 1254);
    zero_img();
    set_range(0, 9);
    show();

    clear_slots();
    rom_mode = 2;
    set_slot(0, 0, 0, 50, 1, 300, 20);
    set_slot(29, 0, 100, 50, 1, 300, 20);
    set_slot(10, 0, 0, 30, 5, 600, 21);
    set_slot(11, 0, 0, 30, 5, 700, 15);
    set_slot(12, 0, 0, 0, 5, 800, 20);
    render(20, c, f);
    check("overlap_latency", c, 1335);
    zero_img();
    set_range(300, 349);
    show();

    clear_slots();
    rom_mode = 1;
    set_slot(0, 0, 0, 50, 1, 300, 20);
    set_slot(29, 0, 100, 50, 1, 300, 20);
    render(20, c, f);
    check("both_opaque_latency", c, 1335);
    show();

    clear_slots();
    rom_mode = 3;
    set_slot(0, 0, 0, 10, 1, 300, 20);
    set_slot(29, 0, 0, 10, 1, 305, 20);
    render(20, c, f);
    zero_img();
    for (int x = 301; x <= 309; x += 2) exp_img[x] = 1'b1;
    for (int x = 306; x <= 314; x += 2) exp_img[x] = 1'b1;
    show();

    clear_slots();
    rom_mode = 1;
    set_slot(29, 0, 0, 200, 5, 500, 0);
    start(0);
    c = 0;
    while (!rom_rd && c < 2000) begin
      tick();
      c++;
    end
    check("fetch_reached", rom_rd, 1);
    line_req = 1'b1;
    tick();
    c++;
    line_req = 1'b0;
    check("overrun_set", overrun, 1);
    check("overrun_still_busy", busy, 1);
    wait_done(c2, f);
    check("overrun_latency", c + c2, 1434);
    check("overrun_sticky", overrun, 1);
    zero_img();
    set_range(500, 699);
    show();

    clear_slots();
    set_slot(29, 0, 0, 200, 5, 500, 0);
    start(0);
    c = 0;
    while (!rom_rd && c < 2000) begin
      tick();
      c++;
    end
    check("fetch_reached2", rom_rd, 1);
    rst = 1'b1;
    tick();
    check("abort_busy", busy, 0);
    check("abort_overrun", overrun, 0);
    check("abort_rom_rd", rom_rd, 0);
    check("abort_line_done", line_done, 0);
    rst = 1'b0;
    tick();
    zero_img();
    read_front();
    clear_slots();
    render(3, c, f);
    check("post_reset_latency", c, 1233);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
